// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file with an integrated busy scoreboard for the in-order datapath.
// Register 0 is hard-wired to zero. Destination registers are marked busy at
// issue and freed at write-back. Same-cycle write-back forwarding to the read
// ports is available through a parameter.
//
// Parameters:
//   DATA_WIDTH - register width in bits
//   ADDR_WIDTH - address width (depth = 2**ADDR_WIDTH)
//   BYPASS     - 1: forward the write-back port to the read ports in the same cycle
//
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   raddr1/2           - read addresses
//   rdata1/2, rbusy1/2 - combinational read data and busy flag
//   wen, waddr, wdata  - write-back port
//   iss_valid/iss_addr - issue request marking iss_addr busy
//   iss_ready          - issue can be accepted this cycle
//   busy_cnt           - number of registers currently busy
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    output logic                  iss_ready,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH:0]   busy_cnt_q;

    logic wr_fire;
    logic iss_fire;
    logic cnt_inc;
    logic cnt_dec;

    // A busy destination may only be reissued when its producer is writing
    // back in this very cycle. The counter only moves on real bit flips: an
    // issue to an already-clear bit increments; a write-back decrements unless
    // a same-cycle issue to that register keeps the bit set.
    always_comb begin
        wr_fire   = wen && (waddr != '0);
        iss_ready = (iss_addr == '0) || !busy[iss_addr] || (wen && (waddr == iss_addr));
        iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
        cnt_inc   = iss_fire && !busy[iss_addr];
        cnt_dec   = wr_fire && busy[waddr] && !(iss_fire && (iss_addr == waddr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[waddr] <= wdata;
        end
    end

    // The set is placed after the clear so a same-cycle issue to the
    // written register leaves it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_fire) begin
                busy[waddr] <= 1'b0;
            end
            if (iss_fire) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt_q <= busy_cnt_q + CNT_ONE;
                2'b01:   busy_cnt_q <= busy_cnt_q - CNT_ONE;
                default: busy_cnt_q <= busy_cnt_q;
            endcase
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Forwarded data is by definition the producer's result, so a bypassed
    // read reports not-busy even if the register is still marked busy.
    always_comb begin
        rdata1 = regs[raddr1];
        rbusy1 = busy[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
            rbusy1 = 1'b0;
        end else if (BYPASS && wen && (waddr == raddr1)) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        rbusy2 = busy[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
            rbusy2 = 1'b0;
        end else if (BYPASS && wen && (waddr == raddr2)) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Self-checking bench for reg_file_sb. Two instances share all inputs: one
// with forwarding enabled and one without, so the same stimulus shows the
// difference between the two read-port behaviours.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] raddr1 = '0, raddr2 = '0, waddr = '0, iss_addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          wen = 1'b0, iss_valid = 1'b0;

    logic [DW-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic          rbusy1, rbusy2, iss_ready, nb_rbusy1, nb_rbusy2, nb_iss_ready;
    logic [AW:0]   busy_cnt, nb_busy_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic [DW-1:0] value;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .iss_ready(iss_ready), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .rbusy1(nb_rbusy1), .rbusy2(nb_rbusy2),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .iss_ready(nb_iss_ready), .busy_cnt(nb_busy_cnt)
    );

    task automatic push_exp(input string n, input logic [DW-1:0] v);
        exp_t x;
        x.name  = n;
        x.value = v;
        sb.push_back(x);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(31 - a);
            push_exp("reset rdata1", '0);
            push_exp("reset rbusy1", '0);
            push_exp("reset rdata2", '0);
            push_exp("reset rbusy2", '0);
            #1;
            e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s a=%0d: got %h expected %h", e.name, a, rdata1, e.value); end
            e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s a=%0d: got %h expected %h", e.name, a, rbusy1, e.value); end
            e = sb.pop_front(); checks++; if (rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s a=%0d: got %h expected %h", e.name, a, rdata2, e.value); end
            e = sb.pop_front(); checks++; if (rbusy2 !== e.value) begin errors++; $display("[TB] FAIL %s a=%0d: got %h expected %h", e.name, a, rbusy2, e.value); end
        end
        push_exp("reset busy_cnt", '0);
        push_exp("reset iss_ready", 1);
        iss_addr = 5'd7;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd5;
        push_exp("nb old r5", '0);
        #1;
        e = sb.pop_front(); checks++; if (nb_rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, nb_rdata1, e.value); end
        push_exp("r5 port1", 32'hDEADBEEF);
        push_exp("r5 port2", 32'hDEADBEEF);
        push_exp("nb r5 port2", 32'hDEADBEEF);
        push_exp("cnt after plain write", '0);
        step();
        wen = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata2, e.value); end
        e = sb.pop_front(); checks++; if (nb_rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, nb_rdata2, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        wen = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0;
        push_exp("r0 no bypass", '0);
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        push_exp("r0 after write", '0);
        push_exp("nb r0 after write", '0);
        step();
        wen = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (nb_rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, nb_rdata1, e.value); end
    endtask

    task automatic test_bypass();
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; raddr2 = 5'd5;
        push_exp("bypass r7 data", 32'hA5A5A5A5);
        push_exp("bypass r7 busy", '0);
        push_exp("nb r7 old", '0);
        push_exp("bypass other port", 32'hDEADBEEF);
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (nb_rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, nb_rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata2, e.value); end
        push_exp("nb r7 next cycle", 32'hA5A5A5A5);
        push_exp("r7 next cycle", 32'hA5A5A5A5);
        step();
        wen = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (nb_rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, nb_rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
    endtask

    task automatic test_issue();
        iss_valid = 1'b1; iss_addr = 5'd3; raddr1 = 5'd3;
        push_exp("issue r3 ready", 1);
        #1;
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        push_exp("r3 busy", 1);
        push_exp("cnt after issue", 1);
        step();
        iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        iss_valid = 1'b1;
        push_exp("WAW stall ready", 0);
        #1;
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        push_exp("cnt after stalled issue", 1);
        step();
        iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        wen = 1'b1; waddr = 5'd3; wdata = 32'h33; iss_valid = 1'b1;
        push_exp("wb+issue ready", 1);
        push_exp("bypass hides busy", 0);
        push_exp("nb shows busy", 1);
        #1;
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (nb_rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, nb_rbusy1, e.value); end
        push_exp("r3 data updated", 32'h33);
        push_exp("r3 still busy", 1);
        push_exp("cnt wb+issue", 1);
        step();
        wen = 1'b0; iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        wen = 1'b1; waddr = 5'd3; wdata = 32'h34;
        push_exp("cnt after final wb", 0);
        push_exp("r3 free", 0);
        step();
        wen = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
    endtask

    task automatic test_back_to_back();
        int exp_cnt;
        exp_cnt = 0;
        for (int i = 1; i < 32; i++) begin
            iss_valid = 1'b1; iss_addr = AW'(i);
            push_exp("fill cnt", DW'(exp_cnt));
            push_exp("fill ready", 1);
            #1;
            e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s i=%0d: got %0d expected %0d", e.name, i, busy_cnt, e.value); end
            e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s i=%0d: got %0d expected %0d", e.name, i, iss_ready, e.value); end
            step();
            exp_cnt++;
        end
        iss_valid = 1'b0; iss_addr = 5'd10;
        push_exp("full cnt", 31);
        push_exp("full r10 ready", 0);
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end

        iss_valid = 1'b1; iss_addr = 5'd0;
        push_exp("r0 issue ready", 1);
        #1;
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        push_exp("cnt after r0 issue", 31);
        step();
        iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        wen = 1'b1; waddr = 5'd4; wdata = 32'h4;
        push_exp("cnt after wb r4", 30);
        step();
        wen = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        wen = 1'b1; waddr = 5'd9; wdata = 32'h9; iss_valid = 1'b1; iss_addr = 5'd4;
        push_exp("cnt issue r4 + wb r9", 30);
        step();
        wen = 1'b0; iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        exp_cnt = 30;
        for (int i = 1; i < 32; i++) begin
            if (i != 9) begin
                wen = 1'b1; waddr = AW'(i); wdata = DW'(i);
                exp_cnt--;
                push_exp("drain cnt", DW'(exp_cnt));
                step();
                wen = 1'b0;
                #1;
                e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s i=%0d: got %0d expected %0d", e.name, i, busy_cnt, e.value); end
            end
        end
    endtask

    task automatic test_async_reset();
        wen = 1'b1; waddr = 5'd2; wdata = 32'h55;
        step();
        wen = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1'b1; iss_addr = AW'(i);
            step();
        end
        iss_valid = 1'b0; iss_addr = 5'd2; raddr1 = 5'd2; raddr2 = 5'd6;
        push_exp("pre-reset r2", 32'h55);
        push_exp("pre-reset cnt", 4);
        #1;
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        wen = 1'b1; waddr = 5'd6; wdata = 32'h77; iss_valid = 1'b1; iss_addr = 5'd2;
        push_exp("async cnt", 0);
        push_exp("async r2 data", 0);
        push_exp("async r2 busy", 0);
        push_exp("async ready", 1);
        push_exp("reset bypass r6", 32'h77);
        #1;
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end
        e = sb.pop_front(); checks++; if (rdata1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata1, e.value); end
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        e = sb.pop_front(); checks++; if (rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata2, e.value); end
        step();
        wen = 1'b0; iss_valid = 1'b0;
        push_exp("r6 write ignored in reset", 0);
        push_exp("issue ignored in reset", 0);
        #1;
        e = sb.pop_front(); checks++; if (rdata2 !== e.value) begin errors++; $display("[TB] FAIL %s: got %h expected %h", e.name, rdata2, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end

        @(negedge clk);
        rst_n = 1'b1;
        step();
        iss_valid = 1'b1; iss_addr = 5'd2;
        push_exp("post-reset issue ready", 1);
        #1;
        e = sb.pop_front(); checks++; if (iss_ready !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, iss_ready, e.value); end
        push_exp("post-reset r2 busy", 1);
        push_exp("post-reset cnt", 1);
        step();
        iss_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++; if (rbusy1 !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, rbusy1, e.value); end
        e = sb.pop_front(); checks++; if (busy_cnt !== e.value) begin errors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.value); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_write();
        test_bypass();
        test_issue();
        test_back_to_back();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with integrated scoreboard for the in-order CPU datapath. It provides two combinational read ports, one write-back port, and an issue port that marks destination registers busy until written back, plus optional same-cycle write-to-read bypass. It replaces the plain register file between decode (reads, hazard check) and write-back. All registers and busy state clear on reset.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH; register 0 hard-wired to zero
- BYPASS, 1, 1 = same-cycle write-back forwarding to read ports; 0 = none

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- raddr1  in  ADDR_WIDTH  read port 1 address
- raddr2  in  ADDR_WIDTH  read port 2 address
- rdata1  out  DATA_WIDTH  read port 1 data (combinational)
- rdata2  out  DATA_WIDTH  read port 2 data (combinational)
- rbusy1  out  1  register at raddr1 has a pending producer
- rbusy2  out  1  register at raddr2 has a pending producer
- wen  in  1  write-back valid
- waddr  in  ADDR_WIDTH  write-back address
- wdata  in  DATA_WIDTH  write-back data
- iss_valid  in  1  issue request: mark iss_addr busy
- iss_addr  in  ADDR_WIDTH  issue destination
- iss_ready  out  1  issue accepted this cycle when iss_valid && iss_ready
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- State: regs[0..2^ADDR_WIDTH-1], busy[0..2^ADDR_WIDTH-1], busy_cnt counter.
- Write: on edge, if wen && waddr != 0: regs[waddr] <= wdata; busy[waddr] <= 0 unless an accepted issue targets waddr in the same cycle. Write with waddr == 0 has no effect.
- Write to a non-busy register is legal. It updates data and leaves busy_cnt unchanged.
- Issue: iss_ready = (iss_addr == 0) || !busy[iss_addr] || (wen && waddr == iss_addr). This stalls WAW on an outstanding producer but lets a same-cycle write-back free the slot.
- Accepted issue (iss_valid && iss_ready) with iss_addr != 0 sets busy[iss_addr] <= 1. Issue to register 0 is always accepted and changes nothing.
- Same register, accepted issue and write-back in one cycle: data written, busy stays 1, busy_cnt unchanged.
- busy_cnt next value = busy_cnt + (set a previously clear bit) − (clear a previously set bit). Range 0..2^ADDR_WIDTH−1, with no wrap.
- Read, for X in 1, 2:
  - raddrX == 0: rdataX = 0 and rbusyX = 0.
  - BYPASS=1 and wen && waddr == raddrX != 0: rdataX = wdata and rbusyX = 0.
  - Otherwise: rdataX = regs[raddrX] and rbusyX = busy[raddrX].
- Both read ports may address the same register. Behaviour is identical on each port.

## Timing
- Reads are zero-latency combinational from raddr, regs, busy, and, when BYPASS=1, from wen/waddr/wdata.
- A write is visible at the read port the cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- An issue is visible on rbusyX and busy_cnt the cycle after acceptance.
- iss_ready is combinational from iss_addr, busy, wen, and waddr. It does not depend on iss_valid.
- Reset (rst_n low, any time including mid-operation): all regs = 0, busy = 0, busy_cnt = 0 immediately.
- Outputs during reset: rdata1/rdata2 = 0 (bypass still applies if wen is driven), rbusy1/rbusy2 = 0, iss_ready = 1.
- wen and iss_valid are ignored while rst_n is low. Operation resumes on the first rising edge after rst_n is deasserted.

## Test plan
- Reset then read all addresses -> every rdata = 0, rbusy = 0, busy_cnt = 0, iss_ready = 1.
- Write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> 0xDEADBEEF on both. Write 0x1234 to r0 -> reading r0 returns 0.
- BYPASS=1: wen, waddr = 7, wdata = 0xA5A5A5A5, raddr1 = 7 in the same cycle -> rdata1 = 0xA5A5A5A5 and rbusy1 = 0 that cycle. With BYPASS=0 -> old value that cycle, new value the next cycle.
- Issue r3 -> next cycle rbusy for r3 = 1, busy_cnt = 1. Issue r3 again without write-back -> iss_ready = 0 and busy_cnt stays 1. Write-back r3 with a same-cycle issue to r3 -> iss_ready = 1, data updated, busy stays 1, busy_cnt stays 1.
- Issue all of r1..r31 on consecutive cycles -> busy_cnt = 31. Write back r1..r31 -> busy_cnt counts down to 0. In a cycle with issue r4 and write-back of busy r9 -> busy_cnt unchanged.
- Assert rst_n low asynchronously mid-cycle with busy_cnt = 4 and r2 = 0x55 -> immediately busy_cnt = 0 and rdata for r2 = 0. After release, issue r2 -> accepted.
